// File: rtl/rsa_engine_arbiter.sv
// rsa_engine_arbiter: round-robin sharing of one modexp engine with job sequencing and watchdog
module rsa_engine_arbiter #(
  parameter int WIDTH      = 4096,
  parameter int NREQ       = 2,
  parameter int IDW        = 1,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_msg,
  input  logic [NREQ*WIDTH-1:0] req_exp,
  input  logic [NREQ*WIDTH-1:0] req_mod,
  output logic [NREQ-1:0]       req_ack,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  eng_reset,
  output logic                  eng_go,
  output logic [WIDTH-1:0]      eng_message,
  output logic [WIDTH-1:0]      eng_exponent,
  output logic [WIDTH-1:0]      eng_modulus,
  input  logic [WIDTH-1:0]      eng_cypher,
  input  logic                  eng_done
);
  typedef enum logic [2:0] {IDLE, ERST, SETTLE, GO, RESP} state_t;
  state_t state, nxt;
  logic [31:0] cnt;
  logic [IDW-1:0] rr, win;
  logic rst_last, to_hit;
  assign rst_last = cnt == 32'(RST_CYCLES - 1);
  assign to_hit = (TIMEOUT != 0) && (cnt == 32'(TIMEOUT - 1));
  // winner: first requester at or after rr+1; scanning far-to-near leaves the nearest set bit
  always_comb begin
    win = '0;
    for (int k = NREQ; k >= 1; k--)
      if (req[(int'(rr) + k) % NREQ]) win = IDW'((int'(rr) + k) % NREQ);
  end
  // next-state: reset pulse, one settle cycle, go until done or watchdog, then hold response
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = |req ? ERST : IDLE;
      ERST:    nxt = rst_last ? SETTLE : ERST;
      SETTLE:  nxt = GO;
      GO:      nxt = (eng_done || to_hit) ? RESP : GO;
      RESP:    nxt = rsp_ready ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end
  // state plus every registered output; done takes priority over a simultaneous timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      rr           <= IDW'(NREQ - 1);
      req_ack      <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
      eng_reset    <= 1'b1;
      eng_go       <= 1'b0;
      eng_message  <= '0;
      eng_exponent <= '0;
      eng_modulus  <= '0;
    end else begin
      state   <= nxt;
      busy    <= nxt != IDLE;
      req_ack <= '0;
      case (state)
        IDLE: if (|req) begin
          eng_message  <= req_msg[win*WIDTH +: WIDTH];
          eng_exponent <= req_exp[win*WIDTH +: WIDTH];
          eng_modulus  <= req_mod[win*WIDTH +: WIDTH];
          rr           <= win;
          rsp_id       <= win;
          req_ack      <= NREQ'(1) << win;
          cnt          <= '0;
        end
        ERST: begin
          cnt       <= rst_last ? '0 : cnt + 32'd1;
          eng_reset <= !rst_last;
        end
        SETTLE: begin
          eng_go <= 1'b1;
          cnt    <= '0;
        end
        GO: if (eng_done || to_hit) begin
          rsp_data  <= eng_done ? eng_cypher : '0;
          rsp_err   <= !eng_done;
          eng_go    <= 1'b0;
          eng_reset <= 1'b1;
          rsp_valid <= 1'b1;
        end else cnt <= cnt + 32'd1;
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_engine_arbiter.sv
// tb_rsa_engine_arbiter: directed checks of arbitration, sequencing, backpressure, watchdog and reset
module tb_rsa_engine_arbiter;
  localparam int W = 16, N = 2, R = 4, TO = 50;
  logic clk = 1'b0, reset = 1'b1, rsp_ready = 1'b0, hang = 1'b0;
  logic [N-1:0] req = '0, req_ack;
  logic [N*W-1:0] req_msg = '0, req_exp = '0, req_mod = '0;
  logic rsp_valid, rsp_err, busy, eng_reset, eng_go, eng_done;
  logic [0:0] rsp_id;
  logic [W-1:0] rsp_data, eng_message, eng_exponent, eng_modulus, eng_cypher;
  int checks = 0, failures = 0, ack_total = 0, ack0 = 0, bad_ack = 0, ecnt = 0;
  logic prev_busy = 1'b0;

  rsa_engine_arbiter #(.WIDTH(W), .NREQ(N), .IDW(1), .RST_CYCLES(R), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_msg(req_msg), .req_exp(req_exp),
    .req_mod(req_mod), .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .eng_reset(eng_reset), .eng_go(eng_go), .eng_message(eng_message),
    .eng_exponent(eng_exponent), .eng_modulus(eng_modulus), .eng_cypher(eng_cypher),
    .eng_done(eng_done));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] modexp(logic [W-1:0] b, logic [W-1:0] e, logic [W-1:0] m);
    logic [31:0] r = 1, x = 32'(b) % 32'(m);
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % 32'(m);
      x = (x * x) % 32'(m);
    end
    return W'(r);
  endfunction

  // stub engine: answers three cycles after go unless told to hang; done held until engine reset
  always @(posedge clk) begin
    if (eng_reset) begin
      eng_done <= 1'b0;
      eng_cypher <= '0;
      ecnt <= 0;
    end else if (eng_go && !hang) begin
      if (ecnt == 3) begin
        eng_done <= 1'b1;
        eng_cypher <= modexp(eng_message, eng_exponent, eng_modulus);
      end else ecnt <= ecnt + 1;
    end
  end

  // ack monitor: a grant must be decided while the arbiter was idle
  always @(negedge clk) begin
    if (req_ack != 0) begin
      ack_total++;
      if (req_ack[0]) ack0++;
      if (prev_busy) bad_ack++;
    end
    prev_busy = busy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic probe(int w);
    return w == 0 ? rsp_valid : w == 1 ? eng_go : req_ack[w-2];
  endfunction

  task automatic wait_on(input string tag, input int w);
    int n = 0;
    while (!probe(w) && n < 300) begin
      tick;
      n++;
    end
    if (!probe(w)) check(tag, 0, 1);
  endtask

  task automatic set_ops(input int i, input int m, input int e, input int n);
    req_msg[i*W +: W] = W'(m);
    req_exp[i*W +: W] = W'(e);
    req_mod[i*W +: W] = W'(n);
  endtask

  task automatic handshake;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("hs_valid_low", 32'(rsp_valid), 0);
  endtask

  initial begin
    int n, rc, a0, at, unst;
    logic [W-1:0] d0;
    logic [0:0] i0;
    logic [0:0] ids [4];
    logic [W-1:0] dat [4];
    tick;
    tick;
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_engrst", 32'(eng_reset), 1);
    check("rst_go", 32'(eng_go), 0);
    check("rst_ack", 32'(req_ack), 0);
    check("rst_data", 32'(rsp_data), 0);
    check("rst_msg", 32'(eng_message), 0);
    reset = 1'b0;
    tick;
    set_ops(0, 8, 13, 77);
    set_ops(1, 50, 37, 77);

    a0 = ack0;
    req = 2'b01;
    wait_on("t1_ack_to", 2);
    req = 2'b00;
    wait_on("t1_rsp_to", 0);
    check("t1_id", 32'(rsp_id), 0);
    check("t1_data", 32'(rsp_data), 50);
    check("t1_err", 32'(rsp_err), 0);
    handshake;
    check("t1_ack_once", 32'(ack0 - a0), 1);

    req = 2'b10;
    n = 0;
    rc = 0;
    do begin
      tick;
      n++;
      if (n == 1) begin
        check("t2_ack", 32'(req_ack), 2);
        req = 2'b00;
      end
      if (eng_reset && !eng_go) rc++;
    end while (!eng_go && n < 30);
    check("t2_go_latency", 32'(n), R + 2);
    check("t2_rst_cycles", 32'(rc), R);
    check("t2_rst_low_at_go", 32'(eng_reset), 0);
    wait_on("t2_rsp_to", 0);
    check("t2_id", 32'(rsp_id), 1);
    check("t2_data", 32'(rsp_data), 8);
    handshake;

    rsp_ready = 1'b1;
    req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_on("t3_rsp_to", 0);
      ids[j] = rsp_id;
      dat[j] = rsp_data;
      if (j == 3) req = 2'b00;
      tick;
    end
    rsp_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("t3_id%0d", j), 32'(ids[j]), j % 2);
      check($sformatf("t3_data%0d", j), 32'(dat[j]), (j % 2) ? 8 : 50);
    end
    check("t3_ack_in_idle", 32'(bad_ack), 0);

    req = 2'b01;
    wait_on("t4_ack_to", 2);
    req = 2'b10;
    wait_on("t4_rsp_to", 0);
    i0 = rsp_id;
    d0 = rsp_data;
    at = ack_total;
    unst = 0;
    for (int j = 0; j < 20; j++) begin
      tick;
      if (rsp_valid !== 1'b1 || rsp_id !== i0 || rsp_data !== d0) unst++;
    end
    check("t4_stable", 32'(unst), 0);
    check("t4_held_data", 32'(d0), 50);
    check("t4_no_ack", 32'(ack_total - at), 0);
    handshake;
    wait_on("t4_ack1_to", 3);
    req = 2'b00;
    wait_on("t4_rsp1_to", 0);
    check("t4_id1", 32'(rsp_id), 1);
    check("t4_data1", 32'(rsp_data), 8);
    handshake;

    hang = 1'b1;
    req = 2'b01;
    wait_on("t5_ack_to", 2);
    req = 2'b00;
    wait_on("t5_go_to", 1);
    n = 0;
    while (!rsp_valid && n < 200) begin
      tick;
      n++;
    end
    check("t5_timeout_cycles", 32'(n), TO);
    check("t5_err", 32'(rsp_err), 1);
    check("t5_data", 32'(rsp_data), 0);
    check("t5_go_dropped", 32'(eng_go), 0);
    handshake;
    hang = 1'b0;
    req = 2'b10;
    wait_on("t5_ack1_to", 3);
    req = 2'b00;
    wait_on("t5_rsp1_to", 0);
    check("t5_next_err", 32'(rsp_err), 0);
    check("t5_next_data", 32'(rsp_data), 8);
    handshake;

    req = 2'b01;
    wait_on("t6_ack_to", 2);
    req = 2'b00;
    wait_on("t6_go_to", 1);
    reset = 1'b1;
    tick;
    check("t6_go", 32'(eng_go), 0);
    check("t6_engrst", 32'(eng_reset), 1);
    check("t6_busy", 32'(busy), 0);
    check("t6_valid", 32'(rsp_valid), 0);
    check("t6_id", 32'(rsp_id), 0);
    check("t6_msg", 32'(eng_message), 0);
    reset = 1'b0;
    rc = 0;
    for (int j = 0; j < 15; j++) begin
      tick;
      if (rsp_valid) rc++;
    end
    check("t6_no_rsp", 32'(rc), 0);
    req = 2'b11;
    tick;
    check("t6_rr_restart", 32'(req_ack), 1);
    req = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "simulation time limit reached");
  end
endmodule
